fl_sub32_pipe: RTL

//  IEEE-754 single-precision subtractor, out = in0 - in1, 4-stage pipeline with valid/ready handshake.

---
 rtl/fl_pkg.sv | 48 ++++
 rtl/fl_sub32_pipe_lzc28.sv | 17 +
 rtl/fl_sub32_pipe.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fl_pkg.sv
// Shared FP32 constants and types for the floating-point datapath.
//   EXP_BIAS / EXP_MAX / QNAN / FRAC_W : FP32 format constants
//   FLG_*                              : bit positions inside the 4-bit flags word
//                                        {invalid, overflow, underflow, inexact}
//   fl_unpacked_t                      : decoded operand (denormals flushed to zero)
//   fl_carry_t                         : per-operation fields carried down the pipeline
package fl_pkg;

  localparam int          EXP_BIAS      = 127;
  localparam logic [7:0]  EXP_MAX       = 8'hFF;
  localparam logic [31:0] QNAN          = 32'h7FC0_0000;
  localparam int          FRAC_W        = 23;

  localparam int          FLG_INVALID   = 3;
  localparam int          FLG_OVERFLOW  = 2;
  localparam int          FLG_UNDERFLOW = 1;
  localparam int          FLG_INEXACT   = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fl_unpacked_t;

  // sp/sp_res: special-case result decided up front, bypasses the arithmetic.
  typedef struct packed {
    logic        sp;
    logic [31:0] sp_res;
    logic        sign;
    logic [7:0]  exp;
  } fl_carry_t;

  // Denormals (exp == 0) are flushed to a signed zero with an empty mantissa.
  function automatic fl_unpacked_t fl_unpack(input logic [31:0] x);
    fl_unpacked_t u;
    u.sign    = x[31];
    u.exp     = x[30:23];
    u.is_zero = (x[30:23] == 8'h00);
    u.is_inf  = (x[30:23] == EXP_MAX) && (x[FRAC_W-1:0] == '0);
    u.is_nan  = (x[30:23] == EXP_MAX) && (x[FRAC_W-1:0] != '0);
    u.mant    = u.is_zero ? 24'h0 : {1'b1, x[FRAC_W-1:0]};
    return u;
  endfunction

endpackage

// File: rtl/fl_sub32_pipe_lzc28.sv
// lzc28: combinational leading-zero count of a 28-bit vector.
//   val : input vector
//   cnt : number of zeros above the most significant set bit (28 when val == 0)
module lzc28 (
  input  logic [27:0] val,
  output logic [4:0]  cnt
);

  // Ascending scan: the last hit is the highest set bit.
  always_comb begin
    cnt = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (val[i]) cnt = 5'(27 - i);
    end
  end

endmodule

// File: rtl/fl_sub32_pipe.sv
// fl_sub32_pipe: FP32 subtractor, out = in0 - in1, 4-stage pipeline, FTZ, round-to-nearest-even.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready = ~out_valid | out_ready)
//   in0, in1             : minuend, subtrahend
//   out_valid / out_ready: result handshake; out held while stalled
//   out                  : difference
//   flags                : {invalid, overflow, underflow, inexact}, present only when
//                          FLSUB_FLAGS_EN is defined
// All stages share one advance enable; a stall freezes the whole pipe (no bubble collapse).
module fl_sub32_pipe
  import fl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in0,
  input  logic [31:0] in1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
`ifdef FLSUB_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  logic advance;
  logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
  logic vld_p1_d, vld_p2_d, vld_p3_d, vld_p4_d;

  fl_carry_t   carry_p1_q, carry_p1_d, carry_p2_q, carry_p2_d, carry_p3_q, carry_p3_d;
  logic        eff_sub_p1_q, eff_sub_p1_d, eff_sub_p2_q, eff_sub_p2_d;
  logic [23:0] mant_a_p1_q, mant_a_p1_d, mant_b_p1_q, mant_b_p1_d;
  logic [7:0]  diff_p1_q, diff_p1_d;
  logic [23:0] mant_a_p2_q, mant_a_p2_d;
  logic [26:0] b_al_p2_q, b_al_p2_d;
  logic [27:0] sum_p3_q, sum_p3_d;
  logic [31:0] out_q, out_d;

  assign advance   = ~vld_p4_q | out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_p4_q;
  assign out       = out_q;

  // ---- S1: unpack, specials, order by magnitude ----
  fl_unpacked_t ua, ub;
  logic [31:0]  b_flip;
  logic         sp_s1, a_big_s1;
  logic [31:0]  sp_res_s1;

  always_comb begin
    b_flip    = {~in1[31], in1[30:0]};
    ua        = fl_unpack(in0);
    ub        = fl_unpack(b_flip);
    a_big_s1  = (in0[30:0] >= in1[30:0]);
    sp_s1     = 1'b1;
    sp_res_s1 = QNAN;
    if (ua.is_nan || ub.is_nan)      sp_res_s1 = QNAN;
    else if (ua.is_inf && ub.is_inf) sp_res_s1 = (ua.sign != ub.sign) ? QNAN : {ua.sign, EXP_MAX, 23'h0};
    else if (ua.is_inf)              sp_res_s1 = {ua.sign, EXP_MAX, 23'h0};
    else if (ub.is_inf)              sp_res_s1 = {ub.sign, EXP_MAX, 23'h0};
    // Two zeros keep a negative sign only when both effective signs are negative.
    else if (ua.is_zero && ub.is_zero) sp_res_s1 = {ua.sign & ub.sign, 31'h0};
    else if (ua.is_zero)             sp_res_s1 = b_flip;
    else if (ub.is_zero)             sp_res_s1 = in0;
    else                             sp_s1     = 1'b0;
  end

  // ---- S2: align smaller mantissa into {m, G, R, S} ----
  logic [26:0] b_ext_s2, lost_s2, b_al_s2;

  always_comb begin
    b_ext_s2 = {mant_b_p1_q, 3'b000};
    lost_s2  = b_ext_s2 & ~(27'h7FF_FFFF << diff_p1_q);
    if (diff_p1_q >= 8'd27) b_al_s2 = 27'd1;
    else                    b_al_s2 = (b_ext_s2 >> diff_p1_q) | {26'd0, |lost_s2};
  end

  // ---- S3: magnitude add/subtract (A >= B, so never negative) ----
  logic [27:0] sum_s3;

  always_comb begin
    if (eff_sub_p2_q) sum_s3 = {1'b0, mant_a_p2_q, 3'b000} - {1'b0, b_al_p2_q};
    else              sum_s3 = {1'b0, mant_a_p2_q, 3'b000} + {1'b0, b_al_p2_q};
  end

  // ---- S4: normalise, round, pack ----
  logic [4:0]         lzc_s4;
  logic signed [9:0]  exp_n_s4, exp_r_s4;
  logic [26:0]        norm_s4;
  logic [24:0]        mant_r_s4;
  logic               rnd_up_s4;
  logic [31:0]        res_s4;
`ifdef FLSUB_FLAGS_EN
  logic [3:0]         flg_s4, flags_q, flags_d;
  assign flags = flags_q;
`endif

  lzc28 u_lzc (.val(sum_p3_q), .cnt(lzc_s4));

  always_comb begin
    // lzc == 0 is the carry case: exponent +1 and a right shift folding bit 0 into sticky.
    exp_n_s4 = $signed({2'b00, carry_p3_q.exp}) + 10'sd1 - $signed({5'b00000, lzc_s4});
    if (lzc_s4 == 5'd0) norm_s4 = {sum_p3_q[27:2], sum_p3_q[1] | sum_p3_q[0]};
    else                norm_s4 = 27'(sum_p3_q << (lzc_s4 - 5'd1));
    rnd_up_s4 = norm_s4[2] & (norm_s4[1] | norm_s4[0] | norm_s4[3]);
    mant_r_s4 = {1'b0, norm_s4[26:3]} + 25'(rnd_up_s4);
    exp_r_s4  = exp_n_s4 + $signed({9'd0, mant_r_s4[24]});
    res_s4    = 32'h0;
`ifdef FLSUB_FLAGS_EN
    flg_s4    = 4'h0;
`endif
    if (carry_p3_q.sp) begin
      res_s4 = carry_p3_q.sp_res;
`ifdef FLSUB_FLAGS_EN
      flg_s4[FLG_INVALID] = (carry_p3_q.sp_res == QNAN);
`endif
    end else if (sum_p3_q == 28'd0) begin
      res_s4 = 32'h0;
    end else if (exp_n_s4 <= 10'sd0) begin
      res_s4 = {carry_p3_q.sign, 31'h0};
`ifdef FLSUB_FLAGS_EN
      flg_s4[FLG_UNDERFLOW] = 1'b1;
      flg_s4[FLG_INEXACT]   = 1'b1;
`endif
    end else if (exp_r_s4 >= 10'sd255) begin
      res_s4 = {carry_p3_q.sign, EXP_MAX, 23'h0};
`ifdef FLSUB_FLAGS_EN
      flg_s4[FLG_OVERFLOW] = 1'b1;
      flg_s4[FLG_INEXACT]  = 1'b1;
`endif
    end else begin
      res_s4 = {carry_p3_q.sign, exp_r_s4[7:0],
                mant_r_s4[24] ? mant_r_s4[23:1] : mant_r_s4[22:0]};
`ifdef FLSUB_FLAGS_EN
      flg_s4[FLG_INEXACT] = |norm_s4[2:0];
`endif
    end
  end

  always_comb begin
    vld_p1_d     = vld_p1_q;     vld_p2_d     = vld_p2_q;
    vld_p3_d     = vld_p3_q;     vld_p4_d     = vld_p4_q;
    carry_p1_d   = carry_p1_q;   carry_p2_d   = carry_p2_q;   carry_p3_d = carry_p3_q;
    eff_sub_p1_d = eff_sub_p1_q; eff_sub_p2_d = eff_sub_p2_q;
    mant_a_p1_d  = mant_a_p1_q;  mant_b_p1_d  = mant_b_p1_q;  diff_p1_d  = diff_p1_q;
    mant_a_p2_d  = mant_a_p2_q;  b_al_p2_d    = b_al_p2_q;
    sum_p3_d     = sum_p3_q;
    out_d        = out_q;
`ifdef FLSUB_FLAGS_EN
    flags_d      = flags_q;
`endif
    if (advance) begin
      vld_p1_d          = in_valid;
      vld_p2_d          = vld_p1_q;
      vld_p3_d          = vld_p2_q;
      vld_p4_d          = vld_p3_q;
      carry_p1_d.sp     = sp_s1;
      carry_p1_d.sp_res = sp_res_s1;
      carry_p1_d.sign   = a_big_s1 ? ua.sign : ub.sign;
      carry_p1_d.exp    = a_big_s1 ? ua.exp  : ub.exp;
      eff_sub_p1_d      = ua.sign ^ ub.sign;
      mant_a_p1_d       = a_big_s1 ? ua.mant : ub.mant;
      mant_b_p1_d       = a_big_s1 ? ub.mant : ua.mant;
      diff_p1_d         = a_big_s1 ? (ua.exp - ub.exp) : (ub.exp - ua.exp);
      carry_p2_d        = carry_p1_q;
      eff_sub_p2_d      = eff_sub_p1_q;
      mant_a_p2_d       = mant_a_p1_q;
      b_al_p2_d         = b_al_s2;
      carry_p3_d        = carry_p2_q;
      sum_p3_d          = sum_s3;
      if (vld_p3_q) begin
        out_d = res_s4;
`ifdef FLSUB_FLAGS_EN
        flags_d = flg_s4;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      vld_p4_q <= 1'b0;
      out_q    <= 32'h0;
`ifdef FLSUB_FLAGS_EN
      flags_q  <= 4'h0;
`endif
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      vld_p4_q <= vld_p4_d;
      out_q    <= out_d;
`ifdef FLSUB_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    carry_p1_q   <= carry_p1_d;
    carry_p2_q   <= carry_p2_d;
    carry_p3_q   <= carry_p3_d;
    eff_sub_p1_q <= eff_sub_p1_d;
    eff_sub_p2_q <= eff_sub_p2_d;
    mant_a_p1_q  <= mant_a_p1_d;
    mant_b_p1_q  <= mant_b_p1_d;
    diff_p1_q    <= diff_p1_d;
    mant_a_p2_q  <= mant_a_p2_d;
    b_al_p2_q    <= b_al_p2_d;
    sum_p3_q     <= sum_p3_d;
  end

endmodule
